// File: rtl/systolic_pkg.sv
// systolic_pkg: shared defaults and feeder state encoding for the systolic array slice
package systolic_pkg;
  localparam int DEFAULT_ARR_SIZE = 4;
  localparam int DEFAULT_DATA_BW = 16;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} feeder_state_t;
endpackage

// File: rtl/skew_delay_line.sv
// skew_delay_line: DEPTH-stage shift register with synchronous clear
module skew_delay_line #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] sr [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end
  assign dout = sr[DEPTH-1];
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: skews A/B lanes into a diagonal wavefront and frames one array operation
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int ARR_SIZE = DEFAULT_ARR_SIZE,
  parameter int DATA_BW = DEFAULT_DATA_BW,
  parameter int KLEN_BW = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [KLEN_BW-1:0]          k_len,
  input  logic                        mode_in,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_BW*ARR_SIZE-1:0] a_vec,
  input  logic [DATA_BW*ARR_SIZE-1:0] b_vec,
  output logic [DATA_BW*ARR_SIZE-1:0] horizontal_input,
  output logic [DATA_BW*ARR_SIZE-1:0] vertical_input,
  output logic                        i_mode,
  output logic                        busy,
  output logic                        done
);
  feeder_state_t state, state_n;
  logic [KLEN_BW-1:0] cnt, cnt_n, cnt_inc, klen_r;
  logic mode_r, accept, last_beat;
  assign in_ready = state == STREAM;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign i_mode = busy & mode_r;
  assign accept = in_valid & in_ready;
  assign cnt_inc = cnt + 1'b1;
  assign last_beat = cnt_inc == klen_r;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      klen_r <= '0;
      mode_r <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (state == IDLE && start) begin
        klen_r <= k_len;
        mode_r <= mode_in;
      end
    end
  end
  // cnt counts accepted beats in STREAM, then is reused for the drain length
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: begin
        state_n = start ? ((k_len == '0) ? DONE : STREAM) : IDLE;
        cnt_n = '0;
      end
      STREAM: begin
        state_n = (accept && last_beat) ? DRAIN : STREAM;
        cnt_n = accept ? (last_beat ? '0 : cnt_inc) : cnt;
      end
      DRAIN: begin
        state_n = (cnt == KLEN_BW'(ARR_SIZE - 1)) ? DONE : DRAIN;
        cnt_n = cnt_inc;
      end
      default: state_n = IDLE;
    endcase
  end
  // bubbles and idle cycles feed zeros so lanes stay aligned and drain clean
  for (genvar k = 0; k < ARR_SIZE; k++) begin : g_lane
    skew_delay_line #(.WIDTH(DATA_BW), .DEPTH(k + 1)) u_a (
      .clk(clk),
      .rst(rst),
      .din(accept ? a_vec[k*DATA_BW +: DATA_BW] : '0),
      .dout(horizontal_input[k*DATA_BW +: DATA_BW])
    );
    skew_delay_line #(.WIDTH(DATA_BW), .DEPTH(k + 1)) u_b (
      .clk(clk),
      .rst(rst),
      .din(accept ? b_vec[k*DATA_BW +: DATA_BW] : '0),
      .dout(vertical_input[k*DATA_BW +: DATA_BW])
    );
  end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: directed operations with a per-cycle expected-output scoreboard
module tb_systolic_feeder;
  localparam int N = 4;
  localparam int W = 16;
  localparam int KB = 8;
  logic clk = 0, rst = 0, start = 0, mode_in = 0, in_valid = 0;
  logic [KB-1:0] k_len = '0;
  logic [W*N-1:0] a_vec = '0, b_vec = '0, h, v;
  logic in_ready, i_mode, busy, done;
  typedef struct {
    logic [W*N-1:0] h, v;
    logic rdy, busy, done, mode;
  } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  systolic_feeder #(.ARR_SIZE(N), .DATA_BW(W), .KLEN_BW(KB)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .mode_in(mode_in),
    .in_valid(in_valid), .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec),
    .horizontal_input(h), .vertical_input(v), .i_mode(i_mode), .busy(busy), .done(done)
  );

  task automatic chk(input string name, input logic [W*N-1:0] act, input logic [W*N-1:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, want %h", name, $time, act, want);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("horizontal_input", h, e.h);
      chk("vertical_input", v, e.v);
      chk("in_ready", {63'd0, in_ready}, {63'd0, e.rdy});
      chk("busy", {63'd0, busy}, {63'd0, e.busy});
      chk("done", {63'd0, done}, {63'd0, e.done});
      chk("i_mode", {63'd0, i_mode}, {63'd0, e.mode});
    end
  end

  task automatic push(input logic [W*N-1:0] eh, input logic [W*N-1:0] ev,
                      input logic r, input logic b, input logic d, input logic m);
    exp_t e;
    e.h = eh; e.v = ev; e.rdy = r; e.busy = b; e.done = d; e.mode = m;
    q.push_back(e);
  endtask

  task automatic step(input logic r, input logic s, input logic [KB-1:0] kl, input logic md,
                      input logic vld, input logic [W*N-1:0] a, input logic [W*N-1:0] b);
    @(posedge clk);
    #1;
    rst = r; start = s; k_len = kl; mode_in = md; in_valid = vld; a_vec = a; b_vec = b;
  endtask

  function automatic logic [W*N-1:0] mk(input int base);
    logic [W*N-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = 16'(base + k);
    return r;
  endfunction

  // Cycle 0 issues start; lane k in cycle c shows the beat accepted in cycle c-1-k.
  task automatic run_op(input int klen, input logic md, input logic [15:0] vmask,
                        input int seed, input int abort_at, input int ign_at);
    logic [W*N-1:0] acc_a[64], acc_b[64], eh, ev, av, bv;
    int ph, beats, dc;
    logic vld, acc;
    for (int i = 0; i < 64; i++) begin acc_a[i] = '0; acc_b[i] = '0; end
    step(0, 1, KB'(klen), md, 0, '0, '0);
    push('0, '0, 0, 0, 0, 0);
    ph = (klen == 0) ? 3 : 1;
    beats = 0;
    dc = 0;
    for (int c = 1; ph != 4 && c < 60; c++) begin
      eh = '0; ev = '0;
      for (int k = 0; k < N; k++)
        if (c - 1 - k >= 0) begin
          eh[k*W +: W] = acc_a[c-1-k][k*W +: W];
          ev[k*W +: W] = acc_b[c-1-k][k*W +: W];
        end
      vld = (c - 1 < 16) ? vmask[c-1] : 1'b1;
      av = vld ? mk(seed + 16*beats + 1) : {N{16'hdead}};
      bv = vld ? mk(seed + 16*beats + 5) : {N{16'hbeef}};
      step(c == abort_at, c == ign_at, 8'd7, ~md, vld, av, bv);
      push(eh, ev, ph == 1, 1, ph == 3, md);
      if (c == abort_at) begin
        step(0, 0, '0, 0, 0, '0, '0);
        push('0, '0, 0, 0, 0, 0);
        return;
      end
      acc = (ph == 1) && vld;
      if (acc) begin acc_a[c] = av; acc_b[c] = bv; beats++; end
      if (ph == 1 && acc && beats == klen) ph = 2;
      else if (ph == 2) begin dc++; if (dc == N) ph = 3; end
      else if (ph == 3) ph = 4;
    end
    for (int j = 0; j < 2; j++) begin
      step(0, 0, '0, 1, 1, {N{16'h5a5a}}, {N{16'ha5a5}});
      push('0, '0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    step(1, 0, '0, 0, 0, '0, '0);
    step(1, 0, '0, 0, 0, '0, '0);
    push('0, '0, 0, 0, 0, 0);
    step(0, 0, '0, 0, 0, '0, '0);
    push('0, '0, 0, 0, 0, 0);
    run_op(1, 0, 16'hffff, 0, -1, -1);
    run_op(3, 1, 16'hfffd, 32, -1, -1);
    run_op(0, 1, 16'hffff, 0, -1, -1);
    run_op(4, 1, 16'hffff, 64, 2, -1);
    run_op(1, 0, 16'hffff, 0, -1, -1);
    run_op(3, 1, 16'hffff, 96, -1, 2);
    repeat (3) @(posedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
